mult16_seq_ctrl: RTL and testbench

- Sequential 16x16 unsigned shift-add multiplier controller built around one internal 16-bit carry-lookahead adder instance (lookahead_adder).
- Sequences the adder over 16 iterations to produce a 32-bit product.
- Start/busy/done handshake toward the host logic (switch/register front-end in the lab top level).
- FSM, iteration counter and accumulator/multiplier shift registers all live in this block; the adder stays purely combinational.

---
 rtl/mult16_seq_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mult16_seq_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mult16_seq_ctrl.sv
// 16x16 unsigned sequential shift-add multiplier.
// A single 16-bit carry-lookahead adder is sequenced over 16 iterations.
// Each iteration is ADD then SHIFT. With SKIP_ZERO=1, an iteration whose
// multiplier LSB is 0 shifts directly from ADD.

// 16-bit two-level carry-lookahead adder built from four 4-bit groups.
module lookahead_adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    logic [15:0] g;
    logic [15:0] p;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [3:0]  gc;

    assign g = a & b;
    assign p = a ^ b;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_grp
            logic [3:0] gl;
            logic [3:0] pl;
            logic [3:0] cc;

            assign gl = g[4*gi +: 4];
            assign pl = p[4*gi +: 4];

            // In-group carries are expanded fully so that no carry ripples inside a nibble.
            assign cc[0] = gc[gi];
            assign cc[1] = gl[0] | (pl[0] & cc[0]);
            assign cc[2] = gl[1] | (pl[1] & gl[0]) | (pl[1] & pl[0] & cc[0]);
            assign cc[3] = gl[2] | (pl[2] & gl[1]) | (pl[2] & pl[1] & gl[0])
                         | (pl[2] & pl[1] & pl[0] & cc[0]);

            assign s[4*gi +: 4] = pl ^ cc;

            assign gg[gi] = gl[3] | (pl[3] & gl[2]) | (pl[3] & pl[2] & gl[1])
                          | (pl[3] & pl[2] & pl[1] & gl[0]);
            assign gp[gi] = &pl;
        end
    endgenerate

    // The second-level lookahead produces the group carry-ins and the final carry-out.
    assign gc[0] = cin;
    assign gc[1] = gg[0] | (gp[0] & cin);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & cin);
    assign cout  = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0])
                 | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
endmodule

module mult16_seq_ctrl #(
    parameter int SKIP_ZERO = 0
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        start,
    input  logic [15:0] mcand,
    input  logic [15:0] mplier,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] m_reg, m_next;
    logic [15:0] hi_reg, hi_next;
    logic [15:0] lo_reg, lo_next;
    logic        c_reg, c_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] product_reg, product_next;

    logic [15:0] sum;
    logic        sum_cout;
    logic        skip_add;
    logic        do_shift;
    logic        last_iter;

    lookahead_adder u_adder (
        .a    (hi_reg),
        .b    (m_reg),
        .cin  (1'b0),
        .s    (sum),
        .cout (sum_cout)
    );

    // In ADD with a zero multiplier bit, skip mode folds the shift into ADD.
    assign skip_add  = (SKIP_ZERO != 0) && (state_reg == ADD) && !lo_reg[0];
    assign do_shift  = (state_reg == SHIFT) || skip_add;
    assign last_iter = (cnt_reg == 4'd15);

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = ADD;
            ADD:     if (skip_add) state_next = last_iter ? DONE : ADD;
                     else          state_next = SHIFT;
            SHIFT:   state_next = last_iter ? DONE : ADD;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        busy = (state_reg == ADD) || (state_reg == SHIFT);
        done = (state_reg == DONE);
    end

    assign product = product_reg;

    // Datapath next values: operand capture, conditional add, right shift of {c,hi,lo}
    always_comb begin
        m_next       = m_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        c_next       = c_reg;
        cnt_next     = cnt_reg;
        product_next = product_reg;

        if (state_reg == IDLE && start) begin
            m_next   = mcand;
            lo_next  = mplier;
            hi_next  = 16'd0;
            c_next   = 1'b0;
            cnt_next = 4'd0;
        end else if (do_shift) begin
            hi_next = {c_reg, hi_reg[15:1]};
            lo_next = {hi_reg[0], lo_reg[15:1]};
            c_next  = 1'b0;
            if (!last_iter) begin
                cnt_next = cnt_reg + 4'd1;
            end
        end else if (state_reg == ADD) begin
            if (lo_reg[0]) begin
                hi_next = sum;
                c_next  = sum_cout;
            end else begin
                c_next  = 1'b0;
            end
        end

        // The product is loaded on the edge that enters DONE, so it is visible with done.
        if (state_next == DONE && state_reg != DONE) begin
            product_next = {hi_next, lo_next};
        end
    end

    // Datapath registers
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            m_reg       <= 16'd0;
            hi_reg      <= 16'd0;
            lo_reg      <= 16'd0;
            c_reg       <= 1'b0;
            cnt_reg     <= 4'd0;
            product_reg <= 32'd0;
        end else begin
            m_reg       <= m_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            c_reg       <= c_next;
            cnt_reg     <= cnt_next;
            product_reg <= product_next;
        end
    end
endmodule

// File: tb/tb_mult16_seq_ctrl.sv
// Bench for mult16_seq_ctrl: one instance without zero-skip and one with it.
// Expected products are queued at start and checked when done pulses.
module tb_mult16_seq_ctrl;
    logic        Clk;
    logic        Reset_n;
    logic        start0, start1;
    logic [15:0] mcand0, mplier0, mcand1, mplier1;
    logic        busy0, done0, busy1, done1;
    logic [31:0] product0, product1;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sb0[$];
    logic [31:0] sb1[$];

    mult16_seq_ctrl #(.SKIP_ZERO(0)) dut0 (
        .Clk(Clk), .Reset_n(Reset_n), .start(start0),
        .mcand(mcand0), .mplier(mplier0),
        .busy(busy0), .done(done0), .product(product0)
    );

    mult16_seq_ctrl #(.SKIP_ZERO(1)) dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .start(start1),
        .mcand(mcand1), .mplier(mplier1),
        .busy(busy1), .done(done1), .product(product1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end else begin
            $display("ok   %s got=%h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Scoreboard monitors: every done pulse must match the oldest queued expectation.
    always @(posedge Clk) begin
        #1;
        if (done0) begin
            if (sb0.size() == 0) chk("dut0_unexpected_done", 32'd1, 32'd0);
            else                 chk("dut0_product", product0, sb0.pop_front());
        end
        if (done1) begin
            if (sb1.size() == 0) chk("dut1_unexpected_done", 32'd1, 32'd0);
            else                 chk("dut1_product", product1, sb1.pop_front());
        end
    end

    // One operation: accept, then count cycles to the done pulse (cycle T+1 is count 1).
    task automatic run_op(input bit sel, input logic [15:0] a, input logic [15:0] b,
                          input int exp_lat);
        int cycles;
        int busy_cnt;
        if (sel) begin mcand1 = a; mplier1 = b; start1 = 1'b1; end
        else     begin mcand0 = a; mplier0 = b; start0 = 1'b1; end
        tick();
        if (sel) sb1.push_back({16'd0, a} * {16'd0, b});
        else     sb0.push_back({16'd0, a} * {16'd0, b});
        start0 = 1'b0;
        start1 = 1'b0;
        // Operand changes after capture must have no effect.
        if (sel) begin mcand1 = ~a; mplier1 = ~b; end
        else     begin mcand0 = ~a; mplier0 = ~b; end
        cycles   = 1;
        busy_cnt = 0;
        while (!(sel ? done1 : done0) && cycles < 100) begin
            if (sel ? busy1 : busy0) busy_cnt++;
            tick();
            cycles++;
        end
        chk(sel ? "dut1_latency" : "dut0_latency", 32'(cycles), 32'(exp_lat));
        chk(sel ? "dut1_busy_cycles" : "dut0_busy_cycles", 32'(busy_cnt), 32'(exp_lat - 1));
        chk(sel ? "dut1_busy_in_done" : "dut0_busy_in_done", 32'(sel ? busy1 : busy0), 32'd0);
        tick();
        chk(sel ? "dut1_done_single" : "dut0_done_single", 32'(sel ? done1 : done0), 32'd0);
    endtask

    initial begin
        int cycles;
        logic [15:0] ra, rb;

        Reset_n = 1'b0;
        start0 = 1'b0; start1 = 1'b0;
        mcand0 = 16'd0; mplier0 = 16'd0; mcand1 = 16'd0; mplier1 = 16'd0;
        repeat (3) tick();
        chk("reset_busy0", 32'(busy0), 32'd0);
        chk("reset_done0", 32'(done0), 32'd0);
        chk("reset_product0", product0, 32'd0);
        chk("reset_product1", product1, 32'd0);
        Reset_n = 1'b1;
        tick();

        // Basic product with exact latency, then product hold in IDLE.
        run_op(1'b0, 16'h0003, 16'h0005, 33);
        repeat (3) tick();
        chk("dut0_product_hold", product0, 32'h0000000F);

        run_op(1'b0, 16'hFFFF, 16'hFFFF, 33);
        run_op(1'b0, 16'h1234, 16'h0000, 33);
        run_op(1'b0, 16'h0000, 16'hABCD, 33);

        // Start held through the whole op with operands changed mid-op.
        mcand0 = 16'h00FF; mplier0 = 16'h0100; start0 = 1'b1;
        tick();
        sb0.push_back(32'h0000FF00);
        mcand0 = 16'hFFFF; mplier0 = 16'hFFFF;
        cycles = 1;
        while (!done0 && cycles < 100) begin tick(); cycles++; end
        chk("hold_latency", 32'(cycles), 32'd33);
        tick();
        chk("hold_idle_busy", 32'(busy0), 32'd0);
        sb0.push_back(32'hFFFE0001);
        tick();
        chk("hold_reaccept_busy", 32'(busy0), 32'd1);
        chk("hold_product_kept", product0, 32'h0000FF00);
        start0 = 1'b0;
        cycles = 1;
        while (!done0 && cycles < 100) begin tick(); cycles++; end
        chk("reaccept_latency", 32'(cycles), 32'd33);
        tick();

        // Reset in the middle of an op aborts it with no done pulse.
        mcand0 = 16'h1234; mplier0 = 16'h5678; start0 = 1'b1;
        tick();
        sb0.push_back(32'h1234 * 32'h5678);
        start0 = 1'b0;
        repeat (9) tick();
        Reset_n = 1'b0;
        tick();
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_done", 32'(done0), 32'd0);
        chk("abort_product", product0, 32'd0);
        Reset_n = 1'b1;
        void'(sb0.pop_back());
        repeat (40) tick();
        run_op(1'b0, 16'h0007, 16'h0009, 33);

        // Zero-skip instance: latency depends on the multiplier popcount.
        run_op(1'b1, 16'h8000, 16'h0001, 18);
        run_op(1'b1, 16'h0001, 16'hFFFF, 33);
        run_op(1'b1, 16'hFFFF, 16'h0000, 17);

        // A few random operands on both instances.
        for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_op(1'b0, ra, rb, 33);
            run_op(1'b1, ra, rb, 17 + $countones(rb));
        end

        repeat (3) tick();
        chk("sb0_drained", 32'(sb0.size()), 32'd0);
        chk("sb1_drained", 32'(sb1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
